// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command queue: port offsets, STATUS bit map, FSM states, queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

    // Port offsets from PORT_BASE
    localparam logic [15:0] ADDR_OFS = 16'd0;
    localparam logic [15:0] DATA_OFS = 16'd1;
    localparam logic [15:0] CTRL_OFS = 16'd2;
    localparam logic [15:0] STAT_OFS = 16'd3;
    localparam logic [15:0] RX_OFS   = 16'd4;

    // STATUS low-byte bit positions; the occupancy count sits at [15:8]
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_RXV   = 3;
    localparam int ST_ERR   = 4;
    localparam int ST_OVF   = 5;
    localparam int ST_TMO   = 6;
    localparam int ST_CNT   = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; ports: push/wdat in, pop/rdat out (show-ahead), flush, full/empty/count.
// Latency: a push is visible at rdat/count one edge later; rdat always shows the head combinationally.
// Backpressure: push while full is dropped, pop while empty is ignored, flush overrides both.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdat    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdat;
    end

endmodule

// File: rtl/i2c_cmd_queue.sv
// Queues TramelBlaze I2C transactions and issues them back-to-back to the I2C core; one IRQ on drain/error.
// Latency: push (with go set) -> start after 2 edges; ready rise -> next start 3 cycles; tb_data_o combinational.
// Backpressure: pushes into a full queue are dropped and flagged ovf; launches wait for i2c_ready_i.
// Ports: TramelBlaze side tb_* (port id/data/strobes/irq), core side i2c_* (ready/ack_err/rx in, addr/rw/data/start out).
// Build option: define I2C_TIMEOUT_EN to enable the per-transaction watchdog (TIMEOUT_CYCLES).
module i2c_cmd_queue
    import i2c_pkg::*;
#(
    parameter logic [15:0] PORT_BASE      = 16'h0001,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          CNT_W          = $clog2(FIFO_DEPTH) + 1,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] tb_port_id_i,
    input  logic [15:0] tb_data_i,
    input  logic        tb_write_st_i,
    input  logic        tb_read_st_i,
    input  logic        tb_intr_ack_i,
    output logic        tb_intr_r_o,
    output logic [15:0] tb_data_o,
    input  logic        i2c_ready_i,
    input  logic        i2c_ack_err_i,
    input  logic [7:0]  i2c_rx_data_i,
    output logic [6:0]  i2c_address_o,
    output logic        i2c_rw_o,
    output logic [7:0]  i2c_data_o,
    output logic        i2c_start_o
);

    state_t           state, state_nxt;
    logic             go, intr_en, stg_rw, rx_valid, err, ovf, tmo, intr, ready_q;
    logic [6:0]       stg_addr;
    logic [7:0]       rx_byte;
    cmd_t             head, push_cmd;
    logic             full, empty;
    logic [CNT_W-1:0] count;
    logic             wr_addr, wr_data, wr_ctrl, rd_stat, rd_rx, flush;
    logic             launch, pop, done, ready_rise, tmo_hit, err_set, intr_set;
    logic [15:0]      stat;
    logic             unused_bits;

    assign wr_addr = tb_write_st_i && (tb_port_id_i == PORT_BASE + ADDR_OFS);
    assign wr_data = tb_write_st_i && (tb_port_id_i == PORT_BASE + DATA_OFS);
    assign wr_ctrl = tb_write_st_i && (tb_port_id_i == PORT_BASE + CTRL_OFS);
    assign rd_stat = tb_read_st_i  && (tb_port_id_i == PORT_BASE + STAT_OFS);
    assign rd_rx   = tb_read_st_i  && (tb_port_id_i == PORT_BASE + RX_OFS);
    assign flush   = wr_ctrl && tb_data_i[1];
    assign unused_bits = ^tb_data_i[15:8];

    assign push_cmd = '{rw: stg_rw, addr: stg_addr, data: tb_data_i[7:0]};

    sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_data),
        .wdat  (push_cmd),
        .pop   (pop),
        .flush (flush),
        .rdat  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign ready_rise = i2c_ready_i && !ready_q;

`ifdef I2C_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          in_txn;

    assign in_txn  = (state == S_LAUNCH) || (state == S_BUSY);
    // Fires on the edge where the count would reach TIMEOUT_CYCLES
    assign tmo_hit = in_txn && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                tmo_cnt <= '0;
        else if (!in_txn || tmo_hit) tmo_cnt <= '0;
        else                       tmo_cnt <= tmo_cnt + TW'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        pop       = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (go && !empty && i2c_ready_i) begin
                    launch    = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: if (!i2c_ready_i) state_nxt = S_BUSY;
            S_BUSY:   if (ready_rise)   state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                pop       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (tmo_hit) begin
            pop       = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    assign err_set  = (done && i2c_ack_err_i) || tmo_hit;
    // count <= 1 in DONE means the pop (or an earlier flush) leaves the queue empty
    assign intr_set = intr_en && ((done && (count <= CNT_W'(1))) || err_set);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ready_q       <= 1'b0;
            i2c_start_o   <= 1'b0;
            i2c_address_o <= '0;
            i2c_rw_o      <= 1'b0;
            i2c_data_o    <= '0;
            stg_rw        <= 1'b0;
            stg_addr      <= '0;
            go            <= 1'b0;
            intr_en       <= 1'b0;
            rx_byte       <= '0;
            rx_valid      <= 1'b0;
            err           <= 1'b0;
            ovf           <= 1'b0;
            tmo           <= 1'b0;
            intr          <= 1'b0;
        end else begin
            state       <= state_nxt;
            ready_q     <= i2c_ready_i;
            // start is high for exactly the cycles spent in LAUNCH
            i2c_start_o <= (state_nxt == S_LAUNCH);
            if (launch) begin
                i2c_address_o <= head.addr;
                i2c_rw_o      <= head.rw;
                i2c_data_o    <= head.data;
            end
            if (wr_addr) begin
                stg_rw   <= tb_data_i[7];
                stg_addr <= tb_data_i[6:0];
            end
            if (wr_ctrl) begin
                go      <= tb_data_i[0];
                intr_en <= tb_data_i[2];
            end
            if (err_set) go <= 1'b0;
            if (done && i2c_rw_o) rx_byte <= i2c_rx_data_i;

            if (done && i2c_rw_o)     rx_valid <= 1'b1;
            else if (rd_rx)           rx_valid <= 1'b0;
            if (err_set)              err <= 1'b1;
            else if (rd_stat)         err <= 1'b0;
            if (wr_data && full)      ovf <= 1'b1;
            else if (rd_stat)         ovf <= 1'b0;
            if (tmo_hit)              tmo <= 1'b1;
            else if (rd_stat)         tmo <= 1'b0;
            if (intr_set)             intr <= 1'b1;
            else if (tb_intr_ack_i)   intr <= 1'b0;
        end
    end

    assign tb_intr_r_o = intr;

    always_comb begin
        stat                       = '0;
        stat[ST_CNT +: CNT_W]      = count;
        stat[ST_EMPTY]             = empty;
        stat[ST_FULL]              = full;
        stat[ST_BUSY]              = (state != S_IDLE);
        stat[ST_RXV]               = rx_valid;
        stat[ST_ERR]               = err;
        stat[ST_OVF]               = ovf;
        stat[ST_TMO]               = tmo;
    end

    always_comb begin
        tb_data_o = '0;
        if (rd_stat)    tb_data_o = stat;
        else if (rd_rx) tb_data_o = {8'h00, rx_byte};
    end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
module tb_i2c_cmd_queue;

    localparam logic [15:0] BASE = 16'h0001;
    localparam logic [15:0] P_ADDR = BASE + 16'd0;
    localparam logic [15:0] P_DATA = BASE + 16'd1;
    localparam logic [15:0] P_CTRL = BASE + 16'd2;
    localparam logic [15:0] P_STAT = BASE + 16'd3;
    localparam logic [15:0] P_RX   = BASE + 16'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] tb_port_id_i = '0;
    logic [15:0] tb_data_i = '0;
    logic        tb_write_st_i = 1'b0;
    logic        tb_read_st_i = 1'b0;
    logic        tb_intr_ack_i = 1'b0;
    logic        tb_intr_r_o;
    logic [15:0] tb_data_o;
    logic        i2c_ready_i = 1'b1;
    logic        i2c_ack_err_i = 1'b0;
    logic [7:0]  i2c_rx_data_i = '0;
    logic [6:0]  i2c_address_o;
    logic        i2c_rw_o;
    logic [7:0]  i2c_data_o;
    logic        i2c_start_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    i2c_cmd_queue #(.PORT_BASE(BASE), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tb_port_id_i  (tb_port_id_i),
        .tb_data_i     (tb_data_i),
        .tb_write_st_i (tb_write_st_i),
        .tb_read_st_i  (tb_read_st_i),
        .tb_intr_ack_i (tb_intr_ack_i),
        .tb_intr_r_o   (tb_intr_r_o),
        .tb_data_o     (tb_data_o),
        .i2c_ready_i   (i2c_ready_i),
        .i2c_ack_err_i (i2c_ack_err_i),
        .i2c_rx_data_i (i2c_rx_data_i),
        .i2c_address_o (i2c_address_o),
        .i2c_rw_o      (i2c_rw_o),
        .i2c_data_o    (i2c_data_o),
        .i2c_start_o   (i2c_start_o)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tb_write(input logic [15:0] port, input logic [15:0] dat);
        @(negedge clk);
        tb_port_id_i  = port;
        tb_data_i     = dat;
        tb_write_st_i = 1'b1;
        @(negedge clk);
        tb_write_st_i = 1'b0;
    endtask

    // Read strobe spans one edge, so read side effects land on that edge
    task automatic read_chk(input logic [15:0] port, input logic [15:0] exp, input string tag);
        @(negedge clk);
        tb_port_id_i = port;
        tb_read_st_i = 1'b1;
        #1;
        chk(tag, tb_data_o, exp);
        @(negedge clk);
        tb_read_st_i = 1'b0;
    endtask

    task automatic ack_intr();
        @(negedge clk);
        tb_intr_ack_i = 1'b1;
        @(negedge clk);
        tb_intr_ack_i = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!i2c_start_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " start"}, 16'(i2c_start_o), 16'd1);
    endtask

    // Plays the I2C core for one transaction; returns at the negedge after DONE -> IDLE
    task automatic serve(input logic [6:0] ea, input logic erw, input logic [7:0] ed,
                         input logic nack, input logic [7:0] rx, input string tag);
        wait_start(tag);
        chk({tag, " addr"}, 16'(i2c_address_o), 16'(ea));
        chk({tag, " rw"},   16'(i2c_rw_o),      16'(erw));
        chk({tag, " data"}, 16'(i2c_data_o),    16'(ed));
        i2c_ready_i = 1'b0;
        @(negedge clk);
        chk({tag, " start drop"}, 16'(i2c_start_o), 16'd0);
        repeat (2) @(negedge clk);
        i2c_ack_err_i = nack;
        i2c_rx_data_i = rx;
        i2c_ready_i   = 1'b1;
        repeat (2) @(negedge clk);
        i2c_ack_err_i = 1'b0;
    endtask

    task automatic no_start(input int cycles, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | i2c_start_o;
        end
        chk(tag, 16'(seen), 16'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst start", 16'(i2c_start_o), 16'd0);
        chk("rst intr",  16'(tb_intr_r_o), 16'd0);
        chk("rst addr",  16'(i2c_address_o), 16'd0);
        chk("rst data",  16'(i2c_data_o), 16'd0);
        chk("rst idle data_o", tb_data_o, 16'd0);
        read_chk(P_STAT, 16'h0001, "rst status");

        // Single write transaction, push with go already set: start on 2nd edge
        tb_write(P_CTRL, 16'h0005);
        tb_write(P_ADDR, 16'h0050);
        tb_write(P_DATA, 16'h00A5);
        chk("lat edge1 start", 16'(i2c_start_o), 16'd0);
        @(negedge clk);
        chk("lat edge2 start", 16'(i2c_start_o), 16'd1);
        serve(7'h50, 1'b0, 8'hA5, 1'b0, 8'h00, "t1");
        chk("t1 intr", 16'(tb_intr_r_o), 16'd1);
        read_chk(P_STAT, 16'h0001, "t1 status");
        ack_intr();
        chk("t1 intr ack", 16'(tb_intr_r_o), 16'd0);

        // Overflow: 5 pushes into depth 4 with go off
        tb_write(P_CTRL, 16'h0004);
        tb_write(P_ADDR, 16'h0011);
        for (int i = 1; i <= 5; i++) tb_write(P_DATA, 16'(i));
        read_chk(P_STAT, 16'h0422, "ovf status");
        read_chk(P_STAT, 16'h0402, "ovf cleared");
        read_chk(16'h0000, 16'h0000, "unmapped read");
        tb_write(P_CTRL, 16'h0005);
        serve(7'h11, 1'b0, 8'h01, 1'b0, 8'h00, "q1");
        chk("q1 no intr", 16'(tb_intr_r_o), 16'd0);
        serve(7'h11, 1'b0, 8'h02, 1'b0, 8'h00, "q2");
        serve(7'h11, 1'b0, 8'h03, 1'b0, 8'h00, "q3");
        serve(7'h11, 1'b0, 8'h04, 1'b0, 8'h00, "q4");
        chk("q drain intr", 16'(tb_intr_r_o), 16'd1);
        ack_intr();

        // Read transaction
        tb_write(P_ADDR, 16'h00C8);
        tb_write(P_DATA, 16'h0000);
        serve(7'h48, 1'b1, 8'h00, 1'b0, 8'h3C, "rd");
        read_chk(P_STAT, 16'h0009, "rd status rxv");
        read_chk(P_RX,   16'h003C, "rd rxdata");
        read_chk(P_STAT, 16'h0001, "rd rxv cleared");
        ack_intr();

        // NACK on first of three
        tb_write(P_CTRL, 16'h0004);
        tb_write(P_ADDR, 16'h0022);
        tb_write(P_DATA, 16'h0010);
        tb_write(P_DATA, 16'h0020);
        tb_write(P_DATA, 16'h0030);
        tb_write(P_CTRL, 16'h0005);
        serve(7'h22, 1'b0, 8'h10, 1'b1, 8'h00, "nk");
        chk("nk intr", 16'(tb_intr_r_o), 16'd1);
        no_start(10, "nk halted");
        read_chk(P_STAT, 16'h0210, "nk status");
        read_chk(P_STAT, 16'h0200, "nk err cleared");
        ack_intr();
        tb_write(P_CTRL, 16'h0005);
        serve(7'h22, 1'b0, 8'h20, 1'b0, 8'h00, "nk2");
        serve(7'h22, 1'b0, 8'h30, 1'b0, 8'h00, "nk3");
        chk("nk drain intr", 16'(tb_intr_r_o), 16'd1);
        ack_intr();

        // Flush during BUSY with three queued
        tb_write(P_CTRL, 16'h0004);
        tb_write(P_DATA, 16'h0040);
        tb_write(P_DATA, 16'h0050);
        tb_write(P_DATA, 16'h0060);
        tb_write(P_CTRL, 16'h0005);
        wait_start("fl");
        chk("fl data", 16'(i2c_data_o), 16'h0040);
        i2c_ready_i = 1'b0;
        tb_write(P_CTRL, 16'h0007);
        read_chk(P_STAT, 16'h0005, "fl status busy");
        i2c_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        read_chk(P_STAT, 16'h0001, "fl status idle");
        chk("fl intr", 16'(tb_intr_r_o), 16'd1);
        no_start(10, "fl no launch");

        // Asynchronous reset mid-transaction
        tb_write(P_DATA, 16'h0077);
        wait_start("ar");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar start", 16'(i2c_start_o), 16'd0);
        chk("ar intr",  16'(tb_intr_r_o), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_chk(P_STAT, 16'h0001, "ar status");
        no_start(5, "ar no launch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
